// File: rtl/muldiv_if.sv
// Request/response bundle between the execute-stage controller and the
// multiply/divide unit.
interface muldiv_if;
  localparam int unsigned N = 32;

  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         sign;
  logic [1:0]   oper;
  logic         start;
  logic         cancel;
  logic         busy;
  logic         done;
  logic [N-1:0] hi;
  logic [N-1:0] lo;

  modport master (output a, b, sign, oper, start, cancel,
                  input  busy, done, hi, lo);
  modport slave  (input  a, b, sign, oper, start, cancel,
                  output busy, done, hi, lo);
endinterface

// File: rtl/muldiv.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Magnitude shift-add / restoring divide over 32 cycles, then sign fix-up.
module muldiv (
  input  logic    clk,
  input  logic    rst_n,
  muldiv_if.slave bus
);
  localparam int unsigned N  = 32;
  localparam int unsigned W2 = 2 * N;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    m_q, m_d;
  logic [W2-1:0]   p_q, p_d;
  logic [N-1:0]    rem_q, rem_d;
  logic            div_q, div_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [N-1:0]    hi_q, hi_d;
  logic [N-1:0]    lo_q, lo_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            accept_md, accept_mt;
  logic [N-1:0]    a_mag, b_mag;
  logic [N:0]      mul_sum, div_sh;
  logic            div_ge;
  logic [W2-1:0]   prod_fix;
  logic [N-1:0]    quo_fix, rem_fix;

  assign accept_md = bus.start & ~bus.cancel & ~busy_q & (state_q == IDLE) & ~bus.oper[1];
  assign accept_mt = bus.start & ~bus.cancel & (state_q == IDLE) & bus.oper[1];

  assign a_mag = (bus.sign & bus.a[N-1]) ? (~bus.a + N'(1)) : bus.a;
  assign b_mag = (bus.sign & bus.b[N-1]) ? (~bus.b + N'(1)) : bus.b;

  // m_q holds the multiplicand (MULT) or divisor (DIV); p_q[N-1:0] the multiplier / dividend-quotient
  assign mul_sum  = {1'b0, p_q[W2-1:N]} + {1'b0, m_q};
  assign div_sh   = {rem_q, p_q[N-1]};
  assign div_ge   = (div_sh >= {1'b0, m_q});

  assign prod_fix = qneg_q ? (~p_q + W2'(1)) : p_q;
  assign quo_fix  = qneg_q ? (~p_q[N-1:0] + N'(1)) : p_q[N-1:0];
  assign rem_fix  = rneg_q ? (~rem_q + N'(1)) : rem_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_md) state_d = CALC;
      CALC:    if (bus.cancel) state_d = IDLE;
               else if (cnt_q == CW'(N - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    m_d    = m_q;
    p_d    = p_q;
    rem_d  = rem_q;
    div_d  = div_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    busy_d = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        if (accept_md) begin
          div_d  = bus.oper[0];
          m_d    = bus.oper[0] ? b_mag : a_mag;
          p_d    = {N'(0), bus.oper[0] ? a_mag : b_mag};
          rem_d  = '0;
          cnt_d  = '0;
          qneg_d = bus.sign & (bus.a[N-1] ^ bus.b[N-1]);
          rneg_d = bus.sign & bus.a[N-1];
        end else if (accept_mt) begin
          if (bus.oper[0]) lo_d = bus.a;
          else             hi_d = bus.a;
        end
      end
      CALC: begin
        if (!bus.cancel) begin
          cnt_d = cnt_q + CW'(1);
          if (div_q) begin
            rem_d = div_ge ? N'(div_sh - {1'b0, m_q}) : div_sh[N-1:0];
            p_d   = {p_q[W2-1:N], p_q[N-2:0], div_ge};
          end else begin
            p_d = p_q[0] ? {mul_sum, p_q[N-1:1]} : {1'b0, p_q[W2-1:1]};
          end
        end
      end
      FIX: begin
        if (!bus.cancel) begin
          done_d = 1'b1;
          if (div_q) begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end else begin
            lo_d = prod_fix[N-1:0];
            hi_d = prod_fix[W2-1:N];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      m_q    <= '0;
      p_q    <= '0;
      rem_q  <= '0;
      div_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      m_q    <= m_d;
      p_q    <= p_d;
      rem_q  <= rem_d;
      div_q  <= div_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
